// File: rtl/mic_i2s_tx.sv
// I2S microphone-side transmitter: one-word holding register, serializes a sample into the selected WS slot.
// Optional MIC_TX_REPEAT_LAST_EN: on underrun resend the last transmitted sample instead of zeros.
`timescale 1ns/1ps
module mic_i2s_tx #(
   parameter int DATA_W    = 24,
   parameter int SLOT_BITS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sck_in,
   input  logic              ws_in,
   input  logic              lr_sel,
   input  logic [DATA_W-1:0] sample_data,
   input  logic              sample_valid,
   output logic              sample_ready,
   output logic              sd_out,
   output logic              sd_oe,
   output logic              underrun
);

   // state | meaning
   // IDLE  | slot not ours, pad released
   // ARMED | word loaded, waiting one SCK (I2S delay bit)
   // SHIFT | driving data bits MSB first
   // PAD   | driving zeros until the slot ends, then release
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ARMED = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] PAD   = 2'd3;

   localparam int CNT_W = $clog2(SLOT_BITS);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   logic              sck_s1, sck_s2, sck_d;
   logic              ws_s1, ws_s2, ws_q;
   logic              sck_rise, sck_fall, slot_start, slot_end;
   logic              hold_full;
   logic [DATA_W-1:0] hold_data, shreg, fallback;
   logic [1:0]        state;
   logic [CNT_W-1:0]  bit_cnt;
   logic              end_seen;

`ifdef MIC_TX_REPEAT_LAST_EN
   logic [DATA_W-1:0] last_sample;
   assign fallback = last_sample;
`else
   assign fallback = '0;
`endif

   assign sck_rise   = sck_s2 & ~sck_d;
   assign sck_fall   = ~sck_s2 & sck_d;
   assign slot_start = sck_rise & (ws_s2 == lr_sel) & (ws_q != lr_sel);
   assign slot_end   = sck_rise & (ws_q == lr_sel) & (ws_s2 != lr_sel);
   assign sample_ready = ~hold_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         sck_s1 <= 1'b0;
         sck_s2 <= 1'b0;
         sck_d  <= 1'b0;
         ws_s1  <= 1'b0;
         ws_s2  <= 1'b0;
         ws_q   <= ~lr_sel;
      end else begin
         sck_s1 <= sck_in;
         sck_s2 <= sck_s1;
         sck_d  <= sck_s2;
         ws_s1  <= ws_in;
         ws_s2  <= ws_s1;
         if (sck_rise) ws_q <= ws_s2;
      end
   end

   // A write on the transfer clock lands after the transfer, so it is held for the next slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_full <= 1'b0;
         hold_data <= '0;
      end else begin
         if (slot_start) hold_full <= 1'b0;
         if (sample_valid && sample_ready) begin
            hold_full <= 1'b1;
            hold_data <= sample_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sd_out   <= 1'b0;
         sd_oe    <= 1'b0;
         underrun <= 1'b0;
         shreg    <= '0;
         bit_cnt  <= '0;
         end_seen <= 1'b0;
`ifdef MIC_TX_REPEAT_LAST_EN
         last_sample <= '0;
`endif
      end else begin
         underrun <= 1'b0;
         if (slot_start) begin
            // also covers a lost WS edge: the word in flight is dropped
            state    <= ARMED;
            end_seen <= 1'b0;
            bit_cnt  <= '0;
            sd_oe    <= 1'b0;
            sd_out   <= 1'b0;
            if (hold_full) begin
               shreg <= hold_data;
`ifdef MIC_TX_REPEAT_LAST_EN
               last_sample <= hold_data;
`endif
            end else begin
               shreg    <= fallback;
               underrun <= 1'b1;
            end
         end else if (slot_end && state != IDLE) begin
            end_seen <= 1'b1;
            if (state != PAD) begin
               state  <= PAD;
               sd_out <= 1'b0;
            end
         end else if (sck_fall) begin
            case (state)
               ARMED: begin
                  state   <= SHIFT;
                  sd_oe   <= 1'b1;
                  sd_out  <= shreg[DATA_W-1];
                  shreg   <= {shreg[DATA_W-2:0], 1'b0};
                  bit_cnt <= '0;
               end
               SHIFT: begin
                  if (bit_cnt == LAST_BIT) begin
                     state  <= PAD;
                     sd_out <= 1'b0;
                  end else begin
                     sd_out  <= shreg[DATA_W-1];
                     shreg   <= {shreg[DATA_W-2:0], 1'b0};
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               PAD: begin
                  if (end_seen) begin
                     state  <= IDLE;
                     sd_oe  <= 1'b0;
                     sd_out <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mic_i2s_tx.sv
// Bench for mic_i2s_tx: host-side SCK/WS generator, slot-level reference model and an I2S receiver monitor.
`timescale 1ns/1ps
module tb_mic_i2s_tx;
   localparam int DATA_W    = 24;
   localparam int SLOT_BITS = 32;
   localparam int HALF      = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              sck_in = 1'b0;
   logic              ws_in = 1'b1;
   logic              lr_sel = 1'b0;
   logic [DATA_W-1:0] sample_data = '0;
   logic              sample_valid = 1'b0;
   logic              sample_ready, sd_out, sd_oe, underrun;

   mic_i2s_tx #(.DATA_W(DATA_W), .SLOT_BITS(SLOT_BITS)) dut (
      .clk(clk), .rst(rst), .sck_in(sck_in), .ws_in(ws_in), .lr_sel(lr_sel),
      .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
      .sd_out(sd_out), .sd_oe(sd_oe), .underrun(underrun)
   );

   always #8 clk = ~clk;

   typedef struct packed {
      logic [DATA_W-1:0] word;
      logic              ur;
   } exp_t;

   exp_t              exp_q[$];
   logic [DATA_W-1:0] pending[$];
   logic [DATA_W-1:0] last_tx = '0;
   int n_checks = 0;
   int n_pass   = 0;
   int ur_cnt   = 0;

   function automatic void check(string name, int act, int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, req);
   endfunction

   always @(negedge clk) if (underrun === 1'b1) ur_cnt++;

   // Reference model of one slot: take the buffered sample, else the fallback word.
   task automatic model_slot();
      exp_t e;
      if (pending.size() != 0) begin
         e.word  = pending.pop_front();
         e.ur    = 1'b0;
         last_tx = e.word;
      end else begin
`ifdef MIC_TX_REPEAT_LAST_EN
         e.word = last_tx;
`else
         e.word = '0;
`endif
         e.ur = 1'b1;
      end
      exp_q.push_back(e);
   endtask

   task automatic sck_cycles(input logic lvl, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sck_in = 1'b0;
         if (i == 0 && ws_in !== lvl) begin
            if (lvl == lr_sel) model_slot();
            ws_in = lvl;
         end
         repeat (10) @(negedge clk);
         sck_in = 1'b1;
         repeat (9) @(negedge clk);
      end
   endtask

   task automatic frame();
      sck_cycles(lr_sel, HALF);
      sck_cycles(~lr_sel, HALF);
   endtask

   task automatic load(input logic [DATA_W-1:0] v, input bit extra);
      @(negedge clk);
      check("ready_empty", int'(sample_ready), int'(pending.size() == 0));
      sample_data  = v;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      pending.push_back(v);
      check("ready_full", int'(sample_ready), int'(pending.size() == 0));
      if (extra) begin
         sample_data  = ~v;
         sample_valid = 1'b1;
         @(negedge clk);
         sample_valid = 1'b0;
         check("ready_still_full", int'(sample_ready), int'(pending.size() == 0));
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      pending.delete();
      last_tx = '0;
      @(negedge clk);
      check("rst_oe", int'(sd_oe), 0);
      check("rst_ready", int'(sample_ready), int'(pending.size() == 0));
      rst = 1'b0;
   endtask

   task automatic held_valid_test();
      int v;
      int guard;
      v = 1;
      guard = 0;
      fork
         begin
            repeat (4) @(negedge clk);
            frame(); frame(); frame();
         end
         begin
            @(negedge clk);
            sample_data  = DATA_W'(1);
            sample_valid = 1'b1;
            while (v <= 3 && guard < 6000) begin
               guard++;
               if (sample_ready) begin
                  @(posedge clk);
                  pending.push_back(sample_data);
                  v++;
                  @(negedge clk);
                  if (v <= 3) sample_data = DATA_W'(v);
                  else sample_valid = 1'b0;
               end else @(negedge clk);
            end
            sample_valid = 1'b0;
         end
      join
      check("held_accepts", v - 1, 3);
   endtask

   // Receiver: samples at SCK rises; a word spans rise 1 of our half through rise 0 of the next half.
   initial begin
      logic              prev_ws;
      int                k, nb, ur_snap;
      bit                collecting, idle_oe, oe_miss, pad_bad;
      logic [DATA_W-1:0] acc, expw;
      exp_t              e;
      prev_ws = 1'b1; k = 0; nb = 0; ur_snap = 0;
      collecting = 0; idle_oe = 0; oe_miss = 0; pad_bad = 0; acc = '0;
      forever begin
         @(posedge sck_in or posedge rst);
         if (rst) begin
            if (collecting && exp_q.size() != 0) void'(exp_q.pop_front());
            collecting = 0;
            idle_oe    = 0;
            ur_snap    = ur_cnt;
            prev_ws    = ws_in;
         end else begin
            if (ws_in !== prev_ws) k = 0;
            else k++;
            prev_ws = ws_in;
            if (ws_in == lr_sel && k == 0) begin
               if (sd_oe !== 1'b0) idle_oe = 1;
               check("oe_idle", int'(idle_oe), 0);
               idle_oe = 0; collecting = 1; nb = 0; acc = '0; oe_miss = 0; pad_bad = 0;
            end else if (collecting) begin
               if (sd_oe !== 1'b1) oe_miss = 1;
               if (nb < DATA_W) acc = {acc[DATA_W-2:0], sd_out};
               else if (sd_out !== 1'b0) pad_bad = 1;
               nb++;
               if (ws_in != lr_sel && k == 0) begin
                  check("exp_avail", int'(exp_q.size() != 0), 1);
                  if (exp_q.size() != 0) begin
                     e = exp_q.pop_front();
                     expw = (nb < DATA_W) ? (e.word >> (DATA_W - nb)) : e.word;
                     check("word", int'(acc), int'(expw));
                     check("oe_in_word", int'(oe_miss), 0);
                     check("pad_zero", int'(pad_bad), 0);
                     check("underrun_pulses", ur_cnt - ur_snap, int'(e.ur));
                  end
                  ur_snap = ur_cnt;
                  collecting = 0;
               end
            end else if (sd_oe !== 1'b0) idle_oe = 1;
         end
      end
   end

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: run did not finish within cycle budget");
      $fatal(1);
   end

   initial begin
      logic [31:0] r;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_oe", int'(sd_oe), 0);
      check("reset_sd", int'(sd_out), 0);
      check("reset_ready", int'(sample_ready), 1);
      check("reset_underrun", int'(underrun), 0);

      load(24'hA50F3C, 1'b0);
      frame();
      load(24'h123456, 1'b0);
      frame();
      frame();

      for (int i = 0; i < 6; i++) begin
         r = $urandom;
         if (r[1:0] != 2'b00) load(DATA_W'($urandom), r[3]);
         frame();
      end

      load(DATA_W'($urandom), 1'b0);
      sck_cycles(lr_sel, 10);
      sck_cycles(~lr_sel, HALF);
      load(DATA_W'($urandom), 1'b0);
      frame();

      held_valid_test();

      load(DATA_W'($urandom), 1'b0);
      sck_cycles(lr_sel, 13);
      load(DATA_W'($urandom), 1'b0);
      @(negedge clk);
      sck_in = 1'b0;
      repeat (5) @(negedge clk);
      pulse_reset();
      sck_cycles(~lr_sel, HALF);
      load(DATA_W'($urandom), 1'b0);
      frame();

      @(negedge clk);
      sck_in = 1'b0;
      repeat (5) @(negedge clk);
      ws_in  = 1'b0;
      lr_sel = 1'b1;
      pulse_reset();
      load(24'h800001, 1'b0);
      frame();
      for (int i = 0; i < 3; i++) begin
         r = $urandom;
         if (r[0]) load(DATA_W'($urandom), 1'b0);
         frame();
      end

      repeat (20) @(negedge clk);
      check("exp_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mic_i2s_tx.md
MIC_I2S_TX -- requirements
Module: mic_i2s_tx

Interface
REQ-001 Parameter DATA_W, default 24: sample width in bits, valid range 8..32.
REQ-002 Parameter SLOT_BITS, default 32: SCK periods per WS half-frame, always >= DATA_W+1.
REQ-003 clk  input  1  system clock, at least 4x the SCK frequency; single clock domain.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 sck_in  input  1  asynchronous microphone bit clock from the host (clk_mic).
REQ-006 ws_in  input  1  asynchronous word select from the host (clk_WS).
REQ-007 lr_sel  input  1  slot select: 0 = transmit while WS low (left), 1 = transmit while WS high (right).
REQ-008 sample_data  input  DATA_W  signed PCM sample to transmit.
REQ-009 sample_valid  input  1  sample_data is valid this cycle.
REQ-010 sample_ready  output  1  holding register is empty; the sample is accepted on valid&ready.
REQ-011 sd_out  output  1  serial data, MSB first.
REQ-012 sd_oe  output  1  output enable for sd_out; 0 = pad released (hi-Z at the top level).
REQ-013 underrun  output  1  one-clk pulse when a slot starts with an empty holding register.

Function
REQ-014 sck_in and ws_in shall each pass through a 2-flop synchronizer; sck_rise and sck_fall shall be 1-clk pulses decoded from the synchronized sck and its previous value.
REQ-015 ws_in shall be sampled into ws_q only on sck_rise; a slot start is an sck_rise where ws_q changes to the lr_sel level; a slot end is an sck_rise where ws_q leaves that level.
REQ-016 Holding register: accept on sample_valid&sample_ready; sample_ready=0 while full; a second valid while full is ignored, with no stall of the serial side.
REQ-017 FSM states: IDLE, ARMED, SHIFT, PAD.
REQ-018 IDLE -> ARMED on slot start; on that same clk, the holding register moves to the shift register and is marked empty, or, if empty, the underrun fallback (REQ-030) is loaded and underrun pulses.
REQ-019 ARMED -> SHIFT on the next sck_fall (I2S one-bit delay): sd_oe=1 and sd_out=MSB, registered, so the change is visible 1 clk after the sck_fall pulse (3 clk after the raw sck_in edge).
REQ-020 In SHIFT, each subsequent sck_fall shall present the next bit; after DATA_W bits have been driven, the next sck_fall enters PAD with sd_out=0.
REQ-021 In PAD, sd_out=0 and sd_oe=1 until a slot end is seen; the next sck_fall then sets sd_oe=0 and sd_out=0 and returns to IDLE.
REQ-022 A slot end seen in ARMED or SHIFT (short frame) shall force PAD handling: the remaining bits are truncated and sd_oe is released on the following sck_fall.
REQ-023 A slot start seen while not in IDLE (lost WS edge) shall restart at REQ-018 and discard the current word.
REQ-024 If sample_valid arrives on the same clk as a slot-start transfer, the holding register shall accept it after the transfer and the new sample shall be held for the next slot.
REQ-025 A bit counter shall count 0..DATA_W-1 and saturate; there is no wrap into a second word within one slot.
REQ-026 sd_oe shall never be 1 while ws_q is at the opposite slot level for more than one SCK period.

Reset
REQ-027 On rst: FSM=IDLE, sd_out=0, sd_oe=0, underrun=0, holding register empty (sample_ready=1), shift register=0, last-sample register=0, ws_q=~lr_sel, and synchronizers=0.
REQ-028 rst asserted mid-word shall release sd_oe on the next clk; after reset, the first slot start detected shall begin a clean word.

Configuration
REQ-029 Macro MIC_TX_REPEAT_LAST_EN selects the underrun fallback.
REQ-030 With MIC_TX_REPEAT_LAST_EN defined, an underrun reloads the last transmitted sample (0 after reset). Without it, an underrun transmits all-zero data. underrun pulses in both cases.

Verification
REQ-031 clk 60 MHz, SCK 3 MHz, lr_sel=0, sample 24'hA5_0F3C loaded, WS falls -> sd_oe rises 1 SCK after the WS change; sd bits A50F3C MSB first on 24 sck_falls, then 8 zeros; oe drops 1 SCK after WS rises.
REQ-032 lr_sel=1, sample 24'h800001 -> word appears only in the WS-high half-frame; sd_oe=0 throughout the WS-low half.
REQ-033 No sample loaded at slot start -> underrun single 1-clk pulse; data 0 without the macro, previous 24'h123456 repeated with MIC_TX_REPEAT_LAST_EN.
REQ-034 sample_valid held high across 3 frames with values 1, 2, 3 -> exactly one accept per slot, words 1, 2, 3 in order, no underrun.
REQ-035 WS toggled after 10 SCK (short frame) -> 10 MSBs driven, then oe released on the next sck_fall, FSM in IDLE, next full frame correct.
REQ-036 rst pulsed at bit 12 of a word -> sd_oe=0 the next clk; sample_ready=1; next slot transmits a freshly loaded sample intact.
